// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory.
// RV32I funct3 size encodings, the legal-size check and the response pipe record.
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // One slot of the load response pipe.
    typedef struct packed {
        logic        valid;
        logic        fault;
        logic [31:0] data;
    } rsp_t;

    // Unsigned variants only make sense for loads; 011/110/111 are never legal.
    function automatic logic is_legal_size(input logic we, input logic [2:0] size);
        case (size)
            SZ_B, SZ_H, SZ_W: return 1'b1;
            SZ_BU, SZ_HU:     return ~we;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bytelane_if.sv
// Request/response bus of the byte-lane data memory.
//   req_valid/req_we/req_size/req_addr/req_wdata : access request (master -> slave)
//   rsp_valid/rsp_rdata/rsp_fault                : load response / fault (slave -> master)
interface dmem_bytelane_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [2:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_fault;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one 32-bit word.
//   addr[1:0], size   : byte offset and funct3 size of the access
//   wdata             : right-aligned store data
//   rword             : current contents of the addressed word
//   wmask, wshifted   : per-byte write enables and store data moved to its lanes
//   rext              : selected load lanes, right-aligned and sign/zero extended
//   misalign          : H/HU on an odd byte, or W not on a word boundary
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] wshifted,
    output logic [31:0] rext,
    output logic        misalign
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rword[{addr, 3'b000} +: 8];
    assign lane_h = rword[{addr[1], 4'b0000} +: 16];

    always_comb begin
        wmask    = 4'b0000;
        wshifted = 32'h0;
        rext     = 32'h0;
        misalign = 1'b0;
        case (size)
            SZ_B, SZ_BU: begin
                wmask    = 4'b0001 << addr;
                wshifted = {24'h0, wdata[7:0]} << {addr, 3'b000};
                rext     = (size == SZ_B) ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
            end
            SZ_H, SZ_HU: begin
                misalign = addr[0];
                wmask    = addr[1] ? 4'b1100 : 4'b0011;
                wshifted = addr[1] ? {wdata[15:0], 16'h0} : {16'h0, wdata[15:0]};
                rext     = (size == SZ_H) ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
            end
            SZ_W: begin
                misalign = |addr;
                wmask    = 4'b1111;
                wshifted = wdata;
                rext     = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressed RV32I data memory with byte/half/word loads and stores,
// fault detection and a configurable load latency (0 = combinational read).
//   clk, rst    : clock, synchronous active-low reset
//   bus         : dmem_bytelane_if slave (request in, response out)
//   stat_*      : saturating load/store/fault counters, only when DMEM_STATS_EN is defined
// Optional build macro: DMEM_STATS_EN.
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int    DEPTH     = 1024,
    parameter int    ADDR_W    = 32,
    parameter int    LATENCY   = 0,
    parameter string INIT_FILE = ""
) (
    input  logic           clk,
    input  logic           rst,
    dmem_bytelane_if.slave bus
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]    stat_loads,
    output logic [31:0]    stat_stores,
    output logic [31:0]    stat_faults
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    // One bit wider than the address so DEPTH*4 == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH) << 2;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  widx;
    logic [31:0]       rword;
    logic [3:0]        wmask;
    logic [31:0]       wshifted;
    logic [31:0]       rext;
    logic              misalign;
    logic              out_of_range;
    logic              fault;
    logic              acc;
    logic              is_load;
    logic              do_store;

    assign addr         = bus.req_addr;
    assign widx         = addr[IDX_W+1:2];
    assign rword        = mem[widx];
    assign out_of_range = {1'b0, addr} >= LIMIT;
    assign fault        = ~is_legal_size(bus.req_we, bus.req_size) | misalign | out_of_range;
    assign acc          = rst & bus.req_valid;
    assign is_load      = acc & ~bus.req_we;
    assign do_store     = acc & bus.req_we & ~fault;

    dmem_lane_align u_align (
        .addr     (addr[1:0]),
        .size     (bus.req_size),
        .wdata    (bus.req_wdata),
        .rword    (rword),
        .wmask    (wmask),
        .wshifted (wshifted),
        .rext     (rext),
        .misalign (misalign)
    );

    // Array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[widx][8*i +: 8] <= wshifted[8*i +: 8];
            end
        end
    end

    if (LATENCY == 0) begin : g_comb
        assign bus.rsp_valid = is_load;
        assign bus.rsp_rdata = (is_load & ~fault) ? rext : 32'h0;
        assign bus.rsp_fault = acc & fault;
    end else begin : g_pipe
        rsp_t pipe [LATENCY];

        // Store faults ride the pipe with valid=0 so they appear LATENCY cycles later too.
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
            end else begin
                pipe[0] <= '{valid: is_load,
                             fault: acc & fault,
                             data:  (is_load & ~fault) ? rext : 32'h0};
                for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
            end
        end

        // Gated by rst so the response is silent from the first cycle reset is held.
        assign bus.rsp_valid = rst & pipe[LATENCY-1].valid;
        assign bus.rsp_rdata = (rst & pipe[LATENCY-1].valid) ? pipe[LATENCY-1].data : 32'h0;
        assign bus.rsp_fault = rst & pipe[LATENCY-1].fault;
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_loads  <= 32'h0;
            stat_stores <= 32'h0;
            stat_faults <= 32'h0;
        end else begin
            if (is_load & ~fault && stat_loads != 32'hFFFF_FFFF)
                stat_loads <= stat_loads + 32'd1;
            if (do_store && stat_stores != 32'hFFFF_FFFF)
                stat_stores <= stat_stores + 32'd1;
            if (acc & fault && stat_faults != 32'hFFFF_FFFF)
                stat_faults <= stat_faults + 32'd1;
        end
    end
`endif

endmodule
